// File: rtl/receptor_medida.sv
// receptor_medida: 7O1 serial receiver for the range-finder link.
// Deserializes characters from entrada_serial, assembles a
// three-digit ASCII reading terminated by '#', and publishes it
// as 12-bit BCD on medida together with a one-cycle pronto strobe.
module receptor_medida #(
  parameter int BAUD_DIV = 434  // clock cycles per bit, must be >= 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro_serial,
  output logic        erro_formato,
  output logic [3:0]  db_estado
);

  localparam int TW = $clog2(BAUD_DIV);
  // Last timer value of a full bit period and of the half-bit start delay.
  localparam logic [TW-1:0] C_FIM_BIT  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] C_MEIO_BIT = TW'(BAUD_DIV / 2 - 1);

  localparam logic [6:0] C_ASCII_0    = 7'h30;
  localparam logic [6:0] C_ASCII_9    = 7'h39;
  localparam logic [6:0] C_TERMINADOR = 7'h23;

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    ENTREGA  = 4'd5
  } t_estado;

  // Line synchronizer
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  // Character receiver state
  t_estado       r_estado;
  t_estado       w_estado_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_next;
  logic [6:0]    r_dados;
  logic [6:0]    w_dados_next;
  logic          r_paridade;
  logic          w_paridade_next;
  logic          r_parada;
  logic          w_parada_next;
  // Cleared by a low stop bit; a new start bit is only accepted once
  // the line has been seen high again, so a break is not re-received.
  logic          r_armado;
  logic          w_armado_next;

  // Message assembler state
  logic [1:0]    r_slot;
  logic [1:0]    w_slot_next;
  logic [3:0]    r_cent;
  logic [3:0]    w_cent_next;
  logic [3:0]    r_dez;
  logic [3:0]    w_dez_next;
  logic [3:0]    r_uni;
  logic [3:0]    w_uni_next;

  // Registered outputs
  logic [11:0]   r_medida;
  logic [11:0]   w_medida_next;
  logic          r_pronto;
  logic          w_pronto_next;
  logic          r_erro_serial;
  logic          w_erro_serial_next;
  logic          r_erro_formato;
  logic          w_erro_formato_next;

  // Character classification
  logic w_char_ok;
  logic w_digito;
  logic w_terminador;

  assign w_rx = r_sync2;

  // Odd parity over data plus parity bit, and a high stop bit.
  assign w_char_ok    = (^{r_dados, r_paridade}) && r_parada;
  assign w_digito     = (r_dados >= C_ASCII_0) && (r_dados <= C_ASCII_9);
  assign w_terminador = (r_dados == C_TERMINADOR);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= entrada_serial;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic for the bit receiver and the message assembler.
  always_comb begin
    w_estado_next       = r_estado;
    w_timer_next        = r_timer + TW'(1);
    w_bit_idx_next      = r_bit_idx;
    w_dados_next        = r_dados;
    w_paridade_next     = r_paridade;
    w_parada_next       = r_parada;
    w_armado_next       = w_rx ? 1'b1 : r_armado;
    w_slot_next         = r_slot;
    w_cent_next         = r_cent;
    w_dez_next          = r_dez;
    w_uni_next          = r_uni;
    w_medida_next       = r_medida;
    w_pronto_next       = 1'b0;
    w_erro_serial_next  = 1'b0;
    w_erro_formato_next = 1'b0;

    case (r_estado)
      OCIOSO: begin
        w_timer_next = '0;
        if (!w_rx && r_armado) begin
          w_estado_next = INICIO;
        end
      end

      INICIO: begin
        // Re-check the start bit at mid-bit; a high level means a glitch.
        if (r_timer == C_MEIO_BIT) begin
          w_timer_next = '0;
          if (w_rx) begin
            w_estado_next = OCIOSO;
          end else begin
            w_estado_next  = DADOS;
            w_bit_idx_next = 3'd0;
          end
        end
      end

      DADOS: begin
        if (r_timer == C_FIM_BIT) begin
          w_timer_next = '0;
          w_dados_next = {w_rx, r_dados[6:1]};  // LSB arrives first
          if (r_bit_idx == 3'd6) begin
            w_estado_next = PARIDADE;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

      PARIDADE: begin
        if (r_timer == C_FIM_BIT) begin
          w_timer_next    = '0;
          w_paridade_next = w_rx;
          w_estado_next   = PARADA;
        end
      end

      PARADA: begin
        if (r_timer == C_FIM_BIT) begin
          w_timer_next  = '0;
          w_parada_next = w_rx;
          w_estado_next = ENTREGA;
          if (!w_rx) begin
            w_armado_next = 1'b0;
          end
        end
      end

      ENTREGA: begin
        w_timer_next  = '0;
        w_estado_next = OCIOSO;
        if (!w_char_ok) begin
          w_erro_serial_next = 1'b1;
          w_slot_next        = 2'd0;
        end else if (r_slot == 2'd3) begin
          if (w_terminador) begin
            w_medida_next = {r_cent, r_dez, r_uni};
            w_pronto_next = 1'b1;
          end else begin
            w_erro_formato_next = 1'b1;
          end
          w_slot_next = 2'd0;
        end else if (w_digito) begin
          case (r_slot)
            2'd0:    w_cent_next = r_dados[3:0];
            2'd1:    w_dez_next  = r_dados[3:0];
            default: w_uni_next  = r_dados[3:0];
          endcase
          w_slot_next = r_slot + 2'd1;
        end else begin
          // Includes an early '#': the next character starts a new message.
          w_erro_formato_next = 1'b1;
          w_slot_next         = 2'd0;
        end
      end

      default: begin
        w_estado_next = OCIOSO;
        w_timer_next  = '0;
      end
    endcase
  end

  // State register for receiver, assembler and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_timer        <= '0;
      r_bit_idx      <= 3'd0;
      r_dados        <= 7'd0;
      r_paridade     <= 1'b0;
      r_parada       <= 1'b0;
      r_armado       <= 1'b1;
      r_slot         <= 2'd0;
      r_cent         <= 4'd0;
      r_dez          <= 4'd0;
      r_uni          <= 4'd0;
      r_medida       <= 12'h000;
      r_pronto       <= 1'b0;
      r_erro_serial  <= 1'b0;
      r_erro_formato <= 1'b0;
    end else begin
      r_estado       <= w_estado_next;
      r_timer        <= w_timer_next;
      r_bit_idx      <= w_bit_idx_next;
      r_dados        <= w_dados_next;
      r_paridade     <= w_paridade_next;
      r_parada       <= w_parada_next;
      r_armado       <= w_armado_next;
      r_slot         <= w_slot_next;
      r_cent         <= w_cent_next;
      r_dez          <= w_dez_next;
      r_uni          <= w_uni_next;
      r_medida       <= w_medida_next;
      r_pronto       <= w_pronto_next;
      r_erro_serial  <= w_erro_serial_next;
      r_erro_formato <= w_erro_formato_next;
    end
  end

  assign medida       = r_medida;
  assign pronto       = r_pronto;
  assign erro_serial  = r_erro_serial;
  assign erro_formato = r_erro_formato;
  assign db_estado    = r_estado;

endmodule

// File: tb/tb_receptor_medida.sv
// Directed testbench for receptor_medida: drives 7O1 characters on the
// serial line and checks readings, pulses, latency and FSM state.
`timescale 1ns/1ps
module tb_receptor_medida;

  // Short bit period keeps the run small; odd value exercises BAUD_DIV/2.
  localparam int B = 101;
  // Edge of pronto relative to the edge after which the start bit is driven:
  // 2 sync edges + 1 OCIOSO edge + B/2 start delay + 9*B bits + ENTREGA edge.
  localparam int LAT = 4 + 50 + 9 * B;  // 963

  logic        clock;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] medida;
  logic        pronto;
  logic        erro_serial;
  logic        erro_formato;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor counters (written only by the monitor process)
  int cyc = 0;
  int n_pronto = 0;
  int n_es = 0;
  int n_ef = 0;
  int n_sobrep = 0;
  int n_largo = 0;
  int n_sem_pronto = 0;
  int cyc_pronto = 0;
  logic        pronto_ant = 1'b0;
  logic        es_ant = 1'b0;
  logic        ef_ant = 1'b0;
  logic        reset_ant = 1'b0;
  logic [11:0] medida_ant = 12'h000;

  int t_inicio;
  int b_p, b_es, b_ef;

  receptor_medida #(.BAUD_DIV(B)) dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .medida        (medida),
    .pronto        (pronto),
    .erro_serial   (erro_serial),
    .erro_formato  (erro_formato),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter: value equals the number of rising edges seen.
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (pronto) begin
      n_pronto   <= n_pronto + 1;
      cyc_pronto <= cyc;
    end
    if (erro_serial)  n_es <= n_es + 1;
    if (erro_formato) n_ef <= n_ef + 1;
    if (int'(pronto) + int'(erro_serial) + int'(erro_formato) > 1)
      n_sobrep <= n_sobrep + 1;
    if ((pronto && pronto_ant) || (erro_serial && es_ant) || (erro_formato && ef_ant))
      n_largo <= n_largo + 1;
    if (!reset && !reset_ant && !pronto && (medida != medida_ant))
      n_sem_pronto <= n_sem_pronto + 1;
    pronto_ant <= pronto;
    es_ant     <= erro_serial;
    ef_ant     <= erro_formato;
    reset_ant  <= reset;
    medida_ant <= medida;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic espera(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Send one character; caller is always 1 ns after a rising edge.
  task automatic envia_char(input logic [6:0] c, input logic paridade_ruim);
    logic [9:0] quadro;
    logic       p;
    p = ~(^c) ^ paridade_ruim;
    quadro = {1'b1, p, c, 1'b0};
    t_inicio = cyc;
    for (int i = 0; i < 10; i++) begin
      entrada_serial = quadro[i];
      espera(B);
    end
  endtask

  task automatic marca;
    b_p  = n_pronto;
    b_es = n_es;
    b_ef = n_ef;
  endtask

  int t_hash;

  initial begin
    reset = 1'b1;
    entrada_serial = 1'b1;
    @(posedge clock); #1;
    espera(2);
    reset = 1'b0;

    // Reset and idle
    verifica("rst medida", medida, 12'h000);
    verifica("rst pronto", pronto, 0);
    verifica("rst estado", db_estado, 0);
    marca();
    espera(5000);
    verifica("idle pulsos", (n_pronto - b_p) + (n_es - b_es) + (n_ef - b_ef), 0);
    verifica("idle estado", db_estado, 0);

    // Valid frame "123#" back-to-back
    marca();
    envia_char(7'h31, 1'b0);
    envia_char(7'h32, 1'b0);
    envia_char(7'h33, 1'b0);
    envia_char(7'h23, 1'b0);
    t_hash = t_inicio;
    espera(10);
    verifica("123 pronto", n_pronto - b_p, 1);
    verifica("123 medida", medida, 12'h123);
    verifica("123 latencia", cyc_pronto - t_hash, LAT);
    verifica("123 erros", (n_es - b_es) + (n_ef - b_ef), 0);

    // Parity error on "5", then "6#" lands '#' in slot 1
    marca();
    envia_char(7'h34, 1'b0);
    envia_char(7'h35, 1'b1);
    envia_char(7'h36, 1'b0);
    envia_char(7'h23, 1'b0);
    espera(10);
    verifica("par erro_serial", n_es - b_es, 1);
    verifica("par erro_formato", n_ef - b_ef, 1);
    verifica("par pronto", n_pronto - b_p, 0);
    verifica("par medida", medida, 12'h123);

    // Format error and resync: "0A789#"
    marca();
    envia_char(7'h30, 1'b0);
    envia_char(7'h41, 1'b0);
    envia_char(7'h37, 1'b0);
    envia_char(7'h38, 1'b0);
    envia_char(7'h39, 1'b0);
    envia_char(7'h23, 1'b0);
    espera(10);
    verifica("fmt erro_formato", n_ef - b_ef, 1);
    verifica("fmt erro_serial", n_es - b_es, 0);
    verifica("fmt pronto", n_pronto - b_p, 1);
    verifica("fmt medida", medida, 12'h789);

    // Glitch shorter than half a bit
    marca();
    entrada_serial = 1'b0;
    espera(30);
    entrada_serial = 1'b1;
    verifica("glitch em INICIO", db_estado, 1);
    espera(60);
    verifica("glitch OCIOSO", db_estado, 0);
    verifica("glitch pulsos", (n_pronto - b_p) + (n_es - b_es) + (n_ef - b_ef), 0);

    // Break: line held low for 15 bit times
    marca();
    entrada_serial = 1'b0;
    espera(15 * B);
    verifica("break erro_serial", n_es - b_es, 1);
    verifica("break estado", db_estado, 0);
    entrada_serial = 1'b1;
    espera(2 * B);
    envia_char(7'h33, 1'b0);
    envia_char(7'h32, 1'b0);
    envia_char(7'h31, 1'b0);
    envia_char(7'h23, 1'b0);
    espera(10);
    verifica("break medida", medida, 12'h321);
    verifica("break pronto", n_pronto - b_p, 1);
    verifica("break erro_serial total", n_es - b_es, 1);

    // Reset mid-message
    envia_char(7'h39, 1'b0);
    envia_char(7'h39, 1'b0);
    reset = 1'b1;
    espera(1);
    reset = 1'b0;
    verifica("rst meio medida", medida, 12'h000);
    verifica("rst meio estado", db_estado, 0);
    marca();
    envia_char(7'h30, 1'b0);
    envia_char(7'h34, 1'b0);
    envia_char(7'h32, 1'b0);
    envia_char(7'h23, 1'b0);
    espera(10);
    verifica("rst meio pronto", n_pronto - b_p, 1);
    verifica("rst meio medida 042", medida, 12'h042);
    verifica("rst meio erros", (n_es - b_es) + (n_ef - b_ef), 0);

    // Pulse properties over the whole run
    verifica("pulsos simultaneos", n_sobrep, 0);
    verifica("pulsos largos", n_largo, 0);
    verifica("medida sem pronto", n_sem_pronto, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/receptor_medida.md
# receptor_medida

Serial receiver for the range-finder link: the counterpart of the measurement transmitter that emits each distance reading as an ASCII frame on `saida_serial`. It deserializes 7O1 asynchronous characters, assembles the three-digit-plus-terminator message, and delivers the reading as a 12-bit BCD value with a one-cycle `pronto` strobe. It sits on the host/display side of the link.

## Interface
- BAUD_DIV, 434: clock cycles per bit (50 MHz / 115200 baud); must be ≥ 4.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; forces every register to its reset value on the next edge.
- entrada_serial  in  1  serial line; idle high; asynchronous to `clock`.
- medida  out  12  last valid reading in BCD: [11:8] hundreds, [7:4] tens, [3:0] units. Reset 0x000.
- pronto  out  1  one-cycle pulse when `medida` has just been updated. Reset 0.
- erro_serial  out  1  one-cycle pulse on a parity or stop-bit error. Reset 0.
- erro_formato  out  1  one-cycle pulse on a malformed message. Reset 0.
- db_estado  out  4  receiver FSM state code (debug). Reset 0x0.

## Operation
- Line conditioning: `entrada_serial` passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit.
- Character format: 1 start bit (0), 7 data bits LSB first, odd parity over the 7 data bits, 1 stop bit (1).
- Receiver FSM (db_estado code):
  - OCIOSO (0): wait for synchronized line = 0; then clear the bit timer and go to INICIO.
  - INICIO (1): at timer = BAUD_DIV/2 − 1 (integer division) sample the line; 0 → DADOS with bit index 0; 1 → OCIOSO (glitch, no error).
  - DADOS (2): every BAUD_DIV cycles sample one bit into the shift register, LSB first; after bit index 6 go to PARIDADE.
  - PARIDADE (3): after BAUD_DIV cycles sample the parity bit; go to PARADA.
  - PARADA (4): after BAUD_DIV cycles sample the stop bit; go to ENTREGA.
  - ENTREGA (5): one cycle; if parity is odd and stop = 1, the character is handed to the message assembler; otherwise pulse `erro_serial`, discard the character and reset the assembler to slot 0. Then OCIOSO.
  - Unused codes go to OCIOSO.
- Message assembler (slots 0..3), evaluated only on characters delivered from ENTREGA:
  - Slots 0–2 accept 0x30–0x39; the low nibble is stored in the hundreds/tens/units holding register respectively; advance one slot.
  - Slot 3 accepts 0x23 ('#'): copy the holding registers to `medida`, pulse `pronto`, return to slot 0.
  - Any other character in any slot: pulse `erro_formato`, leave `medida` unchanged, return to slot 0.
  - Resync exception: a '#' arriving in slots 0–2 also pulses `erro_formato` and returns to slot 0, so the next character starts a new message.
- `medida` changes only together with `pronto`. Holding registers are never visible on outputs.

## Timing
- Sampling points fall at mid-bit: start at BAUD_DIV/2 cycles after the synchronized falling edge, then every BAUD_DIV cycles.
- Latency: `pronto`, `erro_serial` and `erro_formato` are asserted in the cycle after the ENTREGA edge for the relevant character, i.e. one cycle after the stop-bit sample plus the ENTREGA cycle. `medida` is valid in the same cycle as `pronto`.
- At most one of `pronto`, `erro_serial` and `erro_formato` is high in any cycle. Each is high for exactly one cycle.
- After ENTREGA the FSM is back in OCIOSO about half a bit before the end of the stop bit, so back-to-back characters with no idle gap are received.
- Reset mid-character or mid-message: the partial character and any held digits are discarded, `medida` returns to 0x000, and reception restarts cleanly on the next start bit.
- A line held low (break): the character is received as data 0x00 with stop = 0, giving `erro_serial`; the FSM then waits in OCIOSO and restarts only after the line goes high and falls again. A low level persisting from the previous character does not count as a new start bit.

## Test plan
- Reset and idle: apply reset for 3 cycles, hold the line high for 5000 cycles → all outputs 0, db_estado = 0, no pulses.
- Valid frame: send "1", "2", "3", "#" (0x31, 0x32, 0x33, 0x23) with correct odd parity at BAUD_DIV = 434, back-to-back → exactly one `pronto` pulse and `medida` = 0x123, asserted in the cycle after the ENTREGA edge for '#'.
- Parity error: send "4", "5" with a bad parity bit on the "5", then "6", "#" → `erro_serial` pulse after "5"; the "6", "#" pair gives an `erro_formato` pulse on '#' (arrives in slot 1); `medida` stays at its previous value and no `pronto`.
- Format error and resync: send "0", "A", "7", "8", "9", "#" → `erro_formato` pulse on "A"; then `pronto` with `medida` = 0x789.
- Glitch rejection: drive a 100-cycle low pulse on the line → FSM returns to OCIOSO from INICIO; no error pulses.
- Reset mid-message: send "9", "9", assert reset for 1 cycle, then send "0", "4", "2", "#" → `medida` = 0x000 immediately after reset, then `pronto` with `medida` = 0x042.
